if_stage: RTL and testbench
===========================

# if_stage

Instruction fetch stage of the five-stage RV32I pipeline: the producer side of the decode stage's `i_instr`/`i_pc` input. It owns the fetch PC and issues word requests to instruction memory over a req/ack handshake with one request outstanding. Returned words are buffered in a small FIFO and presented to ID with a valid/stall handshake. Redirects from EX (branch or jump resolution) flush the buffer and restart fetch.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset.
- `FIFO_DEPTH`, 2, fetch buffer entries; legal values are 2 or 4.

Ports:
- Reset is asynchronous and active-low, as already decided. The design uses one clock.
- `clk`, input, 1, pipeline clock.
- `rst_n`, input, 1, asynchronous active-low reset.
- `o_imem_req`, output, 1, fetch request outstanding.
- `o_imem_addr`, output, 32, word-aligned fetch address, stable while `o_imem_req` is high.
- `i_imem_ack`, input, 1, one-cycle pulse; `i_imem_rdata` is valid in the same cycle.
- `i_imem_rdata`, input, 32, fetched instruction word.
- `i_redirect`, input, 1, one-cycle flush-and-redirect pulse from EX.
- `i_redirect_pc`, input, 32, new fetch target; bits [1:0] are ignored and treated as 0.
- `i_stall`, input, 1, ID cannot accept the presented instruction this cycle.
- `o_valid`, output, 1, `o_instr`/`o_pc` hold a real instruction.
- `o_instr`, output, 32, instruction to ID; 32'h0000_0013 (NOP) when `o_valid` is 0.
- `o_pc`, output, 32, address of `o_instr`; the last popped PC when `o_valid` is 0.

## Operation

- **State machine:**
  - S_IDLE: no request outstanding.
  - S_BUSY: request outstanding; its response will be kept.
  - S_DROP: request outstanding; its response will be discarded.
- **Space rule:** a request may be in flight only if `count + 1 <= FIFO_DEPTH`, where `count` is the number of entries after this cycle's push and pop.
- **S_IDLE:** moves to S_BUSY with `o_imem_addr` = `fetch_pc` when space exists.
- **S_BUSY, ack without redirect:**
  - Push {`o_imem_addr`, `i_imem_rdata`}.
  - Set `fetch_pc` = `o_imem_addr` + 4.
  - If space remains, stay in S_BUSY with the new address. Otherwise go to S_IDLE.
- **S_BUSY, redirect without ack:**
  - Flush the FIFO.
  - Latch the redirect PC into `fetch_pc`.
  - Go to S_DROP. `o_imem_addr` is held, because the address must not change before ack.
- **Redirect with ack in the same cycle (S_BUSY or S_DROP):**
  - Discard the ack data and flush.
  - Next cycle: S_BUSY with `o_imem_addr` = redirect PC.
- **S_DROP:**
  - On ack, discard the data and go to S_BUSY with `o_imem_addr` = `fetch_pc`.
  - A further redirect overwrites `fetch_pc`.
- **Redirect in S_IDLE:** flush; next cycle S_BUSY at the redirect PC.
- **FIFO:**
  - Pop when `o_valid` && !`i_stall`.
  - Push and pop in the same cycle leave `count` unchanged.
  - Redirect overrides both push and pop.
  - The read pointer wraps modulo `FIFO_DEPTH`.
- **Output:** `o_valid` = (`count` != 0). `o_instr`/`o_pc` come from the FIFO head; the NOP rule applies when empty.
- **PC arithmetic:** 32-bit and wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0.
- **Reset mid-request:** the outstanding request is abandoned. Memory must tolerate `o_imem_req` dropping before ack.

## Timing

- **Reset values:**
  - `o_imem_req` = 0.
  - `o_imem_addr` = `RESET_PC`.
  - `o_valid` = 0.
  - `o_instr` = 32'h0000_0013.
  - `o_pc` = `RESET_PC`.
  - State = S_IDLE, `count` = 0.
- **Start-up:** `o_imem_req` rises on the first rising edge after `rst_n` deasserts.
- **Fill latency:** data acked in cycle N is presented on `o_valid` in cycle N+1.
- **Throughput:** ack may arrive in the first cycle of a request. With a zero-wait memory, fetch sustains one instruction per cycle.
- **Redirect:** `o_valid` = 0 in the cycle after `i_redirect`. The first redirected instruction appears no earlier than 2 cycles after the redirect.
- **Stall:** `i_stall` holds `o_instr`/`o_pc` stable. Fetch continues until the FIFO is full, then `o_imem_req` drops.

## Configuration

- **`IF_STATIC_JAL_PREDICT_EN` defined:** a kept ack whose word has opcode 7'b1101111 (JAL) sets the next `fetch_pc` to `o_imem_addr` + sign-extended J-immediate, instead of +4. The JAL itself is still pushed. EX's later redirect to the same target remains correct, just redundant.
- **Undefined:** next `fetch_pc` is always +4 and no predecode logic is present.

## Test plan

- **Reset and sequential fetch:** reset, then a zero-wait memory returning 32'h7FF00293, 32'h00530333 at 0x0, 0x4 -> `o_valid` rises one cycle after the first ack; `o_pc` = 0x0 then 0x4; afterwards `o_imem_addr` = 0x8.
- **Backpressure:** hold `i_stall` = 1 for 5 cycles -> `o_instr` stays 32'h7FF00293; `count` = `FIFO_DEPTH`; `o_imem_req` = 0. Releasing the stall drains entries in order.
- **Redirect while outstanding:** 3-wait memory, redirect to 0x40 one cycle after request to 0x8 -> `o_imem_addr` stays 0x8 until ack, which is discarded; the next request is 0x40; no instruction from 0x8 reaches `o_valid`.
- **Redirect coincident with ack:** ack for 0x8 in the same cycle as a redirect to 0x100 with bits [1:0] = 2'b11 -> the ack is dropped; the next request is 0x100; `o_valid` = 0 in the following cycle.
- **PC wrap:** `RESET_PC` = 32'hFFFF_FFFC -> the second request address is 32'h0.
- **Macro on:** 32'hFE5FF3EF (JAL x7, -28) fetched at 0x20 -> next `o_imem_addr` = 0x4. Macro off -> next `o_imem_addr` = 0x24.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port, EX redirect, and the valid/stall port to ID.
// The master modport is the fetch stage; the slave modport is memory, EX and ID seen as one peer.
interface if_stage_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_stall;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;

  modport master (
    output o_imem_req, o_imem_addr, o_valid, o_instr, o_pc,
    input  i_imem_ack, i_imem_rdata, i_redirect, i_redirect_pc, i_stall
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_valid, o_instr, o_pc,
    output i_imem_ack, i_imem_rdata, i_redirect, i_redirect_pc, i_stall
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction fetch: one outstanding imem request, small fetch FIFO to ID, EX redirect flush.
// Optional macro IF_STATIC_JAL_PREDICT_EN: predecode JAL on kept acks and fetch its target next.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic        clk,
  input logic        rst_n,
  if_stage_if.master bus
);
  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam int          CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} state_t;

  state_t           r_state, w_state_next;
  logic [31:0]      r_fetch_pc, w_fetch_pc_next;
  logic [31:0]      r_addr, w_addr_next;
  logic [31:0]      r_last_pc;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [31:0]      r_buf_instr [FIFO_DEPTH];
  logic [31:0]      r_buf_pc    [FIFO_DEPTH];

  logic        w_push, w_pop, w_space, w_valid;
  logic [31:0] w_redirect_pc, w_seq_pc;

  assign w_redirect_pc = {bus.i_redirect_pc[31:2], 2'b00};
  assign w_valid       = (r_count != '0);
  assign w_push        = (r_state == S_BUSY) && bus.i_imem_ack && !bus.i_redirect;
  assign w_pop         = w_valid && !bus.i_stall && !bus.i_redirect;

  always_comb begin
    w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    if (bus.i_redirect)
      w_count_next = '0;
  end

  // Room for one more in-flight word after this cycle's push/pop
  assign w_space = (w_count_next < CNT_W'(FIFO_DEPTH));

`ifdef IF_STATIC_JAL_PREDICT_EN
  logic [31:0] w_jal_imm;
  assign w_jal_imm = {{12{bus.i_imem_rdata[31]}}, bus.i_imem_rdata[19:12],
                      bus.i_imem_rdata[20], bus.i_imem_rdata[30:21], 1'b0};
  assign w_seq_pc  = (bus.i_imem_rdata[6:0] == 7'b1101111) ? r_addr + w_jal_imm
                                                            : r_addr + 32'd4;
`else
  assign w_seq_pc  = r_addr + 32'd4;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_addr_next     = r_addr;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_redirect) begin
          w_state_next    = S_BUSY;
          w_addr_next     = w_redirect_pc;
          w_fetch_pc_next = w_redirect_pc;
        end else if (w_space) begin
          w_state_next = S_BUSY;
          w_addr_next  = r_fetch_pc;
        end
      end
      S_BUSY: begin
        if (bus.i_redirect && bus.i_imem_ack) begin
          w_addr_next     = w_redirect_pc;
          w_fetch_pc_next = w_redirect_pc;
        end else if (bus.i_redirect) begin
          // Address must hold until the memory acks the abandoned request
          w_state_next    = S_DROP;
          w_fetch_pc_next = w_redirect_pc;
        end else if (bus.i_imem_ack) begin
          w_fetch_pc_next = w_seq_pc;
          w_addr_next     = w_seq_pc;
          w_state_next    = w_space ? S_BUSY : S_IDLE;
        end
      end
      S_DROP: begin
        if (bus.i_redirect && bus.i_imem_ack) begin
          w_state_next    = S_BUSY;
          w_addr_next     = w_redirect_pc;
          w_fetch_pc_next = w_redirect_pc;
        end else if (bus.i_redirect) begin
          w_fetch_pc_next = w_redirect_pc;
        end else if (bus.i_imem_ack) begin
          w_state_next = S_BUSY;
          w_addr_next  = r_fetch_pc;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_addr     <= w_addr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_last_pc <= RESET_PC;
    end else begin
      r_count <= w_count_next;
      if (bus.i_redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop) begin
          r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
          r_last_pc <= r_buf_pc[r_rd_ptr];
        end
      end
    end
  end

  // Storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= bus.i_imem_rdata;
      r_buf_pc[r_wr_ptr]    <= r_addr;
    end
  end

  assign bus.o_imem_req  = (r_state != S_IDLE);
  assign bus.o_imem_addr = r_addr;
  assign bus.o_valid     = w_valid;
  assign bus.o_instr     = w_valid ? r_buf_instr[r_rd_ptr] : NOP;
  assign bus.o_pc        = w_valid ? r_buf_pc[r_rd_ptr] : r_last_pc;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, backpressure, redirects, PC wrap, JAL predecode.
// The memory model acks after memWait cycles of an outstanding request (0 = same cycle).
module tb_if_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic memAuto = 1'b0;
  int   memWait = 0;
  int   waitCnt = 0;
  logic wrapAck = 1'b0;

`ifdef IF_STATIC_JAL_PREDICT_EN
  localparam logic [31:0] JAL_NEXT = 32'h0000_0004;
`else
  localparam logic [31:0] JAL_NEXT = 32'h0000_0024;
`endif

  if_stage_if bus ();
  if_stage_if bus2 ();

  if_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(4)) dutWrap (
    .clk(clk), .rst_n(rst_n), .bus(bus2.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0000: memWord = 32'h7FF0_0293;
      32'h0000_0004: memWord = 32'h0053_0333;
      32'h0000_0020: memWord = 32'hFE5F_F3EF;
      default:       memWord = {a[23:0], 8'h13};
    endcase
  endfunction

  assign bus.i_imem_rdata = memWord(bus.o_imem_addr);
  assign bus.i_imem_ack   = memAuto && bus.o_imem_req && (waitCnt >= memWait);

  always @(posedge clk) begin
    if (!bus.o_imem_req || bus.i_imem_ack) waitCnt <= 0;
    else                                   waitCnt <= waitCnt + 1;
  end

  assign bus2.i_imem_ack    = wrapAck && bus2.o_imem_req;
  assign bus2.i_imem_rdata  = 32'h0000_0013;
  assign bus2.i_redirect    = 1'b0;
  assign bus2.i_redirect_pc = 32'h0;
  assign bus2.i_stall       = 1'b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut;
    rst_n = 1'b0; memAuto = 1'b0; memWait = 0; wrapAck = 1'b0;
    bus.i_stall = 1'b0; bus.i_redirect = 1'b0; bus.i_redirect_pc = 32'h0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; memAuto = 1'b0; memWait = 0; wrapAck = 1'b0;
    bus.i_stall = 1'b0; bus.i_redirect = 1'b0; bus.i_redirect_pc = 32'h0;
    tick; tick;
    checks++; if (bus.o_imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b want 0", bus.o_imem_req); end
    checks++; if (bus.o_imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr: got %h want 00000000", bus.o_imem_addr); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_instr !== 32'h13) begin errors++; $display("[TB] FAIL rst_instr: got %h want 00000013", bus.o_instr); end
    checks++; if (bus.o_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %h want 00000000", bus.o_pc); end
    checks++; if (bus2.o_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL rst_wrap_addr: got %h want fffffffc", bus2.o_imem_addr); end
    checks++; if (bus2.o_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL rst_wrap_pc: got %h want fffffffc", bus2.o_pc); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.o_imem_req !== 1'b0) begin errors++; $display("[TB] FAIL start_req_early: got %b want 0", bus.o_imem_req); end
    tick;
    checks++; if (bus.o_imem_req !== 1'b1) begin errors++; $display("[TB] FAIL start_req: got %b want 1", bus.o_imem_req); end
    checks++; if (bus.o_imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL start_addr: got %h want 00000000", bus.o_imem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_imem_req !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_req: got %b want 0", bus.o_imem_req); end
  endtask

  task automatic test_sequential;
    resetDut;
    memAuto = 1'b1;
    tick;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_ack_cycle_valid: got %b want 0", bus.o_valid); end
    tick;
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_fill_valid: got %b want 1", bus.o_valid); end
    checks++; if (bus.o_instr !== 32'h7FF0_0293) begin errors++; $display("[TB] FAIL seq_instr0: got %h want 7ff00293", bus.o_instr); end
    checks++; if (bus.o_pc !== 32'h0) begin errors++; $display("[TB] FAIL seq_pc0: got %h want 00000000", bus.o_pc); end
    checks++; if (bus.o_imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL seq_addr4: got %h want 00000004", bus.o_imem_addr); end
    tick;
    checks++; if (bus.o_instr !== 32'h0053_0333) begin errors++; $display("[TB] FAIL seq_instr1: got %h want 00530333", bus.o_instr); end
    checks++; if (bus.o_pc !== 32'h4) begin errors++; $display("[TB] FAIL seq_pc1: got %h want 00000004", bus.o_pc); end
    checks++; if (bus.o_imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL seq_addr8: got %h want 00000008", bus.o_imem_addr); end
    memAuto = 1'b0;
    tick;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_empty_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_instr !== 32'h13) begin errors++; $display("[TB] FAIL seq_empty_nop: got %h want 00000013", bus.o_instr); end
    checks++; if (bus.o_pc !== 32'h4) begin errors++; $display("[TB] FAIL seq_last_pc: got %h want 00000004", bus.o_pc); end
  endtask

  task automatic test_backpressure;
    resetDut;
    memAuto = 1'b1;
    bus.i_stall = 1'b1;
    tick;
    tick;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.o_instr !== 32'h7FF0_0293) begin errors++; $display("[TB] FAIL stall_instr[%0d]: got %h want 7ff00293", i, bus.o_instr); end
      checks++; if (bus.o_pc !== 32'h0) begin errors++; $display("[TB] FAIL stall_pc[%0d]: got %h want 00000000", i, bus.o_pc); end
      tick;
    end
    checks++; if (bus.o_imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_full_req: got %b want 0", bus.o_imem_req); end
    bus.i_stall = 1'b0;
    tick;
    checks++; if (bus.o_instr !== 32'h0053_0333) begin errors++; $display("[TB] FAIL drain_instr1: got %h want 00530333", bus.o_instr); end
    checks++; if (bus.o_pc !== 32'h4) begin errors++; $display("[TB] FAIL drain_pc1: got %h want 00000004", bus.o_pc); end
    checks++; if (bus.o_imem_req !== 1'b1) begin errors++; $display("[TB] FAIL drain_req: got %b want 1", bus.o_imem_req); end
    checks++; if (bus.o_imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL drain_addr: got %h want 00000008", bus.o_imem_addr); end
    tick;
    checks++; if (bus.o_pc !== 32'h8) begin errors++; $display("[TB] FAIL drain_pc2: got %h want 00000008", bus.o_pc); end
    checks++; if (bus.o_instr !== 32'h0000_0813) begin errors++; $display("[TB] FAIL drain_instr2: got %h want 00000813", bus.o_instr); end
    memAuto = 1'b0;
  endtask

  task automatic test_redirect_outstanding;
    resetDut;
    memAuto = 1'b1;
    tick; tick; tick;
    memWait = 3;
    tick;
    checks++; if (bus.o_imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL rdo_addr_pre: got %h want 00000008", bus.o_imem_addr); end
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h40;
    tick;
    bus.i_redirect = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdo_valid_after: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_pc !== 32'h4) begin errors++; $display("[TB] FAIL rdo_last_pc: got %h want 00000004", bus.o_pc); end
    checks++; if (bus.o_imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL rdo_addr_hold1: got %h want 00000008", bus.o_imem_addr); end
    checks++; if (bus.o_imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rdo_req_hold: got %b want 1", bus.o_imem_req); end
    tick;
    checks++; if (bus.o_imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL rdo_addr_hold2: got %h want 00000008", bus.o_imem_addr); end
    checks++; if (bus.i_imem_ack !== 1'b1) begin errors++; $display("[TB] FAIL rdo_mem_ack: got %b want 1", bus.i_imem_ack); end
    tick;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdo_dropped_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL rdo_new_addr: got %h want 00000040", bus.o_imem_addr); end
    memWait = 0;
    tick;
    checks++; if (bus.o_pc !== 32'h40) begin errors++; $display("[TB] FAIL rdo_first_pc: got %h want 00000040", bus.o_pc); end
    checks++; if (bus.o_instr !== 32'h0000_4013) begin errors++; $display("[TB] FAIL rdo_first_instr: got %h want 00004013", bus.o_instr); end
    memAuto = 1'b0;
  endtask

  task automatic test_redirect_with_ack;
    resetDut;
    memAuto = 1'b1;
    tick; tick; tick;
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h103;
    tick;
    bus.i_redirect = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rwa_valid_after: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL rwa_addr: got %h want 00000100", bus.o_imem_addr); end
    checks++; if (bus.o_imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rwa_req: got %b want 1", bus.o_imem_req); end
    tick;
    checks++; if (bus.o_pc !== 32'h100) begin errors++; $display("[TB] FAIL rwa_first_pc: got %h want 00000100", bus.o_pc); end
    checks++; if (bus.o_instr !== 32'h0001_0013) begin errors++; $display("[TB] FAIL rwa_first_instr: got %h want 00010013", bus.o_instr); end
    memAuto = 1'b0;
  endtask

  task automatic test_pc_wrap;
    resetDut;
    wrapAck = 1'b1;
    tick;
    checks++; if (bus2.o_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr0: got %h want fffffffc", bus2.o_imem_addr); end
    tick;
    checks++; if (bus2.o_imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr1: got %h want 00000000", bus2.o_imem_addr); end
    checks++; if (bus2.o_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_pc: got %h want fffffffc", bus2.o_pc); end
    wrapAck = 1'b0;
  endtask

  task automatic test_jal;
    resetDut;
    memAuto = 1'b1;
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h20;
    tick;
    bus.i_redirect = 1'b0;
    checks++; if (bus.o_imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL jal_addr: got %h want 00000020", bus.o_imem_addr); end
    tick;
    checks++; if (bus.o_imem_addr !== JAL_NEXT) begin errors++; $display("[TB] FAIL jal_next_addr: got %h want %h", bus.o_imem_addr, JAL_NEXT); end
    checks++; if (bus.o_instr !== 32'hFE5F_F3EF) begin errors++; $display("[TB] FAIL jal_pushed: got %h want fe5ff3ef", bus.o_instr); end
    checks++; if (bus.o_pc !== 32'h20) begin errors++; $display("[TB] FAIL jal_pc: got %h want 00000020", bus.o_pc); end
    memAuto = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset;
    test_sequential;
    test_backpressure;
    test_redirect_outstanding;
    test_redirect_with_ack;
    test_pc_wrap;
    test_jal;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
